// File: rtl/bridge_source_arbiter.sv
// Round-robin arbiter feeding one clock_domain_bridge input word from N_REQ requesters.
// Each accepted word is held for HOLD_CYCLES cycles and tagged with its source id and a toggle.
module bridge_source_arbiter #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int N_REQ       = 4,
  parameter  int HOLD_CYCLES = 4,
  localparam int ID_WIDTH    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       bridge_data,
  output logic [ID_WIDTH-1:0]         bridge_src,
  output logic                        bridge_toggle,
  output logic                        busy
);

  localparam int CNT_WIDTH = $clog2(HOLD_CYCLES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ID_WIDTH-1:0]     src_q, src_d;
  logic                    toggle_q, toggle_d;
  logic                    busy_q, busy_d;

  logic                    grant_found;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic                    accept;

  // Search from the pointer upward with wrap; the first valid requester wins.
  always_comb begin
    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      if (sum >= (ID_WIDTH+1)'(N_REQ)) sum = sum - (ID_WIDTH+1)'(N_REQ);
      cand = sum[ID_WIDTH-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign accept = |(req_ready & req_valid);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    src_d    = src_q;
    toggle_d = toggle_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d   = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          src_d    = grant_idx;
          toggle_d = ~toggle_q;
          ptr_d    = (grant_idx == ID_WIDTH'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
          cnt_d    = CNT_WIDTH'(HOLD_CYCLES-1);
          state_d  = HOLD;
          busy_d   = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      src_q    <= '0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      src_q    <= src_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
    end
  end

  assign bridge_data   = data_q;
  assign bridge_src    = src_q;
  assign bridge_toggle = toggle_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_bridge_source_arbiter.sv
// Self-checking bench for bridge_source_arbiter: fixed vector table, directed corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_bridge_source_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int H  = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     bridge_data;
  logic [IW-1:0]    bridge_src;
  logic             bridge_toggle;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  bridge_source_arbiter #(.DATA_WIDTH(W), .N_REQ(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .bridge_data(bridge_data), .bridge_src(bridge_src),
    .bridge_toggle(bridge_toggle), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: remaining hold cycles, rotating priority start, last loaded word.
  int          m_ptr  = 0;
  int          m_hold = 0;
  logic [W-1:0] m_data = '0;
  int          m_src  = 0;
  logic        m_tog  = 1'b0;
  logic [N-1:0] m_ready;
  logic [N-1:0] seen_ready;

  localparam logic [N*W-1:0] DEF_DATA = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

  function automatic logic [N-1:0] modelReady(input logic r, input logic [N-1:0] v);
    logic [N-1:0] res;
    res = '0;
    if (r && m_hold == 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (v[(m_ptr + k) % N]) res = '0;
        if (v[(m_ptr + k) % N]) res[(m_ptr + k) % N] = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic int onehotIdx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic modelEdge(input logic r, input logic [N*W-1:0] d);
    int g;
    if (!r) begin
      m_ptr = 0; m_hold = 0; m_data = '0; m_src = 0; m_tog = 1'b0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_ready != '0) begin
      g      = onehotIdx(m_ready);
      m_data = d[g*W +: W];
      m_src  = g;
      m_tog  = ~m_tog;
      m_ptr  = (g + 1) % N;
      m_hold = H;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle: ready is sampled mid-cycle, registered outputs 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    @(negedge clk);
    rst_n = r; req_valid = v; req_data = d;
    #1;
    seen_ready = req_ready;
    m_ready    = modelReady(r, v);
    @(posedge clk);
    modelEdge(r, d);
    #1;
  endtask

  task automatic stepCheck(input string tag, input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    applyStimulus(r, v, d);
    checkOutput({tag, ".ready"},  64'(seen_ready),    64'(m_ready));
    checkOutput({tag, ".data"},   64'(bridge_data),   64'(m_data));
    checkOutput({tag, ".src"},    64'(bridge_src),    64'(m_src));
    checkOutput({tag, ".toggle"}, 64'(bridge_toggle), 64'(m_tog));
    checkOutput({tag, ".busy"},   64'(busy),          64'(m_hold > 0));
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] v;
    logic [N*W-1:0] d;
    logic [N-1:0] ready;
    logic [W-1:0] data;
    logic [IW-1:0] src;
    logic         tog;
    logic         bsy;
  } vec_t;

  vec_t vecs[14];
  int   grants[$];
  int   load_cycle[$];
  logic load_tog[$];
  logic saw_r1;
  logic prev_tog;

  initial begin
    logic [N*W-1:0] a5;
    a5 = DEF_DATA;
    a5[2*W +: W] = 16'hA5A5;
    rst_n = 1'b0; req_valid = '0; req_data = '0;

    // Hand-derived cycle table: reset, first grant to req 0, lone req 2, held valid in HOLD.
    vecs[0]  = '{1'b0, 4'b1111, DEF_DATA, 4'b0000, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, DEF_DATA, 4'b0000, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, DEF_DATA, 4'b0000, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, DEF_DATA, 4'b0001, 16'h1000, 2'd0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 4'b0000, DEF_DATA, 4'b0000, 16'h1000, 2'd0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 4'b0000, DEF_DATA, 4'b0000, 16'h1000, 2'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 4'b0000, DEF_DATA, 4'b0000, 16'h1000, 2'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'b0000, DEF_DATA, 4'b0000, 16'h1000, 2'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0100, a5,       4'b0100, 16'hA5A5, 2'd2, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'b0100, DEF_DATA, 4'b0000, 16'hA5A5, 2'd2, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 4'b0100, DEF_DATA, 4'b0000, 16'hA5A5, 2'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'b0100, DEF_DATA, 4'b0000, 16'hA5A5, 2'd2, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'b0000, DEF_DATA, 4'b0000, 16'hA5A5, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'b0011, DEF_DATA, 4'b0001, 16'h1000, 2'd0, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].d);
      checkOutput($sformatf("vec%0d.ready", i),  64'(seen_ready),    64'(vecs[i].ready));
      checkOutput($sformatf("vec%0d.data", i),   64'(bridge_data),   64'(vecs[i].data));
      checkOutput($sformatf("vec%0d.src", i),    64'(bridge_src),    64'(vecs[i].src));
      checkOutput($sformatf("vec%0d.toggle", i), 64'(bridge_toggle), 64'(vecs[i].tog));
      checkOutput($sformatf("vec%0d.busy", i),   64'(busy),          64'(vecs[i].bsy));
    end

    // All four valid: order 0,1,2,3,0 with loads five cycles apart and alternating toggle.
    stepCheck("rr_rst", 1'b0, 4'b1111, DEF_DATA);
    grants.delete(); load_cycle.delete(); load_tog.delete();
    prev_tog = bridge_toggle;
    for (int c = 0; c < 25; c++) begin
      stepCheck("rr", 1'b1, 4'b1111, DEF_DATA);
      if (seen_ready != '0) grants.push_back(onehotIdx(seen_ready));
      if (bridge_toggle != prev_tog) begin
        load_cycle.push_back(c);
        load_tog.push_back(bridge_toggle);
      end
      prev_tog = bridge_toggle;
    end
    checkOutput("rr.count", 64'(grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      checkOutput($sformatf("rr.grant%0d", i), 64'(grants[i]), 64'(i % N));
    for (int i = 1; i < load_cycle.size(); i++)
      checkOutput($sformatf("rr.spacing%0d", i), 64'(load_cycle[i] - load_cycle[i-1]), 64'(H + 1));
    for (int i = 0; i < load_tog.size(); i++)
      checkOutput($sformatf("rr.tog%0d", i), 64'(load_tog[i]), 64'((i + 1) % 2));

    // After a grant to req 1, reqs 0 and 3 pending: 3 wins, then 0.
    stepCheck("ptr_rst", 1'b0, 4'b0000, DEF_DATA);
    stepCheck("ptr_g1", 1'b1, 4'b0010, DEF_DATA);
    checkOutput("ptr.g1", 64'(seen_ready), 64'b0010);
    grants.delete();
    for (int c = 0; c < 10; c++) begin
      stepCheck("ptr", 1'b1, 4'b1001, DEF_DATA);
      if (seen_ready != '0) grants.push_back(onehotIdx(seen_ready));
    end
    checkOutput("ptr.count", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      checkOutput("ptr.first", 64'(grants[0]), 64'd3);
      checkOutput("ptr.second", 64'(grants[1]), 64'd0);
    end

    // Reset during HOLD aborts the hold outright.
    stepCheck("mid_rst0", 1'b0, 4'b0000, DEF_DATA);
    stepCheck("mid_g", 1'b1, 4'b0001, DEF_DATA);
    stepCheck("mid_h1", 1'b1, 4'b0000, DEF_DATA);
    stepCheck("mid_rst", 1'b0, 4'b1111, DEF_DATA);
    checkOutput("mid.busy", 64'(busy), 64'd0);
    checkOutput("mid.toggle", 64'(bridge_toggle), 64'd0);
    checkOutput("mid.data", 64'(bridge_data), 64'd0);
    checkOutput("mid.ready_in_rst", 64'(seen_ready), 64'd0);
    stepCheck("mid_after", 1'b1, 4'b1000, DEF_DATA);
    checkOutput("mid.regrant", 64'(seen_ready), 64'b1000);

    // Req 1 valid only while held off by HOLD: never granted, toggle untouched.
    stepCheck("drop_rst", 1'b0, 4'b0000, DEF_DATA);
    stepCheck("drop_g", 1'b1, 4'b0100, DEF_DATA);
    saw_r1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      stepCheck("drop", 1'b1, (c < 3) ? 4'b0010 : 4'b0000, DEF_DATA);
      if (seen_ready[1]) saw_r1 = 1'b1;
      checkOutput($sformatf("drop.tog%0d", c), 64'(bridge_toggle), 64'd1);
    end
    checkOutput("drop.never_ready1", 64'(saw_r1), 64'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      logic         r;
      logic [N-1:0] v;
      r = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom_range(0, 15));
      stepCheck($sformatf("rnd%0d", c), r, v, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
